// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl
// Brief    : Job sequencer for a ROWS x COLS systolic array (weight load,
//            ifmap stream, ofmap write-back via an L-deep valid pipeline).
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_vec_i,
    input  logic [ADDR_W-1:0] w_base_i,
    input  logic [ADDR_W-1:0] if_base_i,
    input  logic [ADDR_W-1:0] of_base_i,
    output logic              w_rd_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ROWS-1:0]   weight_en_o,
    output logic              if_rd_en_o,
    output logic [ADDR_W-1:0] if_addr_o,
    output logic              of_we_o,
    output logic [ADDR_W-1:0] of_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int LAT = ROWS + COLS;
    localparam int KW  = $clog2(ROWS + 1);
    localparam logic [KW-1:0]   C_K_LAST = KW'(ROWS);
    localparam logic [ROWS-1:0] C_ROW0   = ROWS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [KW-1:0]     r_k;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_vec;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_if_addr;
    logic [ADDR_W-1:0] r_of_addr;
    logic [LAT-1:0]    r_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rd_en_o   = 1'b0;
        weight_en_o = '0;
        if_rd_en_o  = 1'b0;
        done_o      = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                // Row k captures the buffer word one cycle after its read
                if (r_k != C_K_LAST) w_rd_en_o = 1'b1;
                if (r_k != '0) weight_en_o = C_ROW0 << (r_k - KW'(1));
                if (r_k == C_K_LAST) w_next = (r_num == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if_rd_en_o = 1'b1;
                if (r_vec == r_num - CNT_W'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave once only the final stage can still hold a result
                if (r_valid[LAT-2:0] == '0) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign of_we_o   = r_valid[LAT-1];
    assign w_addr_o  = r_w_addr;
    assign if_addr_o = r_if_addr;
    assign of_addr_o = r_of_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k       <= '0;
            r_num     <= '0;
            r_vec     <= '0;
            r_w_addr  <= '0;
            r_if_addr <= '0;
            r_of_addr <= '0;
            r_valid   <= '0;
        end else begin
            r_valid <= {r_valid[LAT-2:0], if_rd_en_o};
            if (of_we_o) r_of_addr <= r_of_addr + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_num     <= num_vec_i;
                        r_w_addr  <= w_base_i;
                        r_if_addr <= if_base_i;
                        r_of_addr <= of_base_i;
                        r_k       <= '0;
                        r_vec     <= '0;
                    end
                end
                S_LOAD_W: begin
                    r_k <= r_k + KW'(1);
                    if (w_rd_en_o) r_w_addr <= r_w_addr + ADDR_W'(1);
                end
                S_STREAM: begin
                    r_vec     <= r_vec + CNT_W'(1);
                    r_if_addr <= r_if_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_ctrl
// Brief    : Scoreboard bench for systolic_array_ctrl (ROWS=COLS=4, L=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LAT  = ROWS + COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] num_vec = '0;
    logic [9:0] w_base = '0;
    logic [9:0] if_base = '0;
    logic [9:0] of_base = '0;
    logic       w_rd_en;
    logic [9:0] w_addr;
    logic [3:0] weight_en;
    logic       if_rd_en;
    logic [9:0] if_addr;
    logic       of_we;
    logic [9:0] of_addr;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       wr;
        logic [9:0] wa;
        logic [3:0] we;
        logic       ir;
        logic [9:0] ia;
        logic       ow;
        logic [9:0] oa;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(10), .CNT_W(10)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec),
        .w_base_i(w_base), .if_base_i(if_base), .of_base_i(of_base),
        .w_rd_en_o(w_rd_en), .w_addr_o(w_addr), .weight_en_o(weight_en),
        .if_rd_en_o(if_rd_en), .if_addr_o(if_addr), .of_we_o(of_we),
        .of_addr_o(of_addr), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_cycle(input exp_t e, input int c);
        string s;
        s = $sformatf("c%0d", c);
        check_val({s, " ctrl"}, 32'({w_rd_en, weight_en, if_rd_en, of_we, busy, done}),
                  32'({e.wr, e.we, e.ir, e.ow, e.busy, e.done}));
        if (e.wr) check_val({s, " w_addr"}, 32'(w_addr), 32'(e.wa));
        if (e.ir) check_val({s, " if_addr"}, 32'(if_addr), 32'(e.ia));
        if (e.ow) check_val({s, " of_addr"}, 32'(of_addr), 32'(e.oa));
    endtask

    // Expected per-cycle outputs, cycle 1 = first cycle after start acceptance
    function automatic int job_len(input int n);
        return (n == 0) ? ROWS + 2 : ROWS + 1 + n + LAT + 1;
    endfunction

    task automatic push_job(input int n, input int wb, input int ib, input int ob);
        int t;
        exp_t e;
        t = job_len(n);
        for (int c = 1; c <= t + 1; c++) begin
            e      = '0;
            e.wr   = (c >= 1 && c <= ROWS);
            e.wa   = 10'(wb + c - 1);
            e.we   = (c >= 2 && c <= ROWS + 1) ? 4'(1 << (c - 2)) : 4'd0;
            e.ir   = (n > 0 && c >= ROWS + 2 && c < ROWS + 2 + n);
            e.ia   = 10'(ib + c - ROWS - 2);
            e.ow   = (n > 0 && c >= ROWS + 2 + LAT && c < ROWS + 2 + LAT + n);
            e.oa   = 10'(ob + c - ROWS - 2 - LAT);
            e.busy = (c <= t);
            e.done = (c == t);
            sb.push_back(e);
        end
    endtask

    task automatic run_job(input int n, input int wb, input int ib, input int ob,
                           input bit spurious, input int abort_at);
        exp_t e;
        int   c;
        num_vec = 10'(n); w_base = 10'(wb); if_base = 10'(ib); of_base = 10'(ob);
        start   = 1'b1;
        check_val("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        num_vec = 10'h3AA; w_base = 10'h155; if_base = 10'h0AA; of_base = 10'h2CC;
        push_job(n, wb, ib, ob);
        c = 1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            compare_cycle(e, c);
            start = spurious && (c == ROWS + 3 || c == job_len(n));
            if (c == abort_at) begin
                rst = 1'b1;
                sb.delete();
                for (int i = 0; i < LAT + 4; i++) sb.push_back('0);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            c++;
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst ctrl", 32'({w_rd_en, weight_en, if_rd_en, of_we, busy, done}), 32'd0);
        check_val("rst addrs", {2'b0, w_addr, if_addr, of_addr}, 32'd0);

        run_job(3, 'h10, 'h20, 'h40, 1'b0, -1);
        run_job(0, 'h55, 'h66, 'h77, 1'b0, -1);
        run_job(2, 'h3FE, 'h3FF, 'h3FD, 1'b0, -1);
        run_job(3, 'h10, 'h20, 'h40, 1'b1, -1);
        run_job(3, 'h10, 'h20, 'h40, 1'b0, 7);
        run_job(3, 'h11, 'h21, 'h41, 1'b0, -1);
        run_job(int'($urandom_range(5, 30)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
